// File: rtl/i2s_mixer.sv
// i2s_mixer: captures CHANNELS I2S serial sources, mixes each slot into one
// word and retransmits it MSB-first one slot later, aligned to wsd.
//
// Parameters:
//   CHANNELS   number of serial data inputs (2 or 4)
//   WORD_W     sample width in bits (8..32)
// Ports:
//   sck        bit clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   ws         word select (0 = left, 1 = right)
//   sd_in      serial data, one bit per source
//   mode       00 = ch0, 01 = XOR, 10 = signed sum, 11 = signed average
//   sd_out     mixed serial stream (one slot latency)
//   wsd        ws registered once
//   wsp        ws ^ wsd, marks a boundary edge
//   word_out   last mixed word
//   word_valid one-cycle strobe, word_out updated
//   word_side  ws value of the slot held in word_out
//   short_slot one-cycle strobe, slot had fewer than WORD_W bits
// Configuration:
//   I2S_MIX_SAT_EN defined   -> mode 10 saturates
//   I2S_MIX_SAT_EN undefined -> mode 10 wraps modulo 2^WORD_W
module i2s_mixer #(
    parameter int CHANNELS = 2,
    parameter int WORD_W   = 16
) (
    input  logic                sck,
    input  logic                rst_n,
    input  logic                ws,
    input  logic [CHANNELS-1:0] sd_in,
    input  logic [1:0]          mode,
    output logic                sd_out,
    output logic                wsd,
    output logic                wsp,
    output logic [WORD_W-1:0]   word_out,
    output logic                word_valid,
    output logic                word_side,
    output logic                short_slot
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int SHIFT = (CHANNELS == 4) ? 2 : 1;
    // Just wide enough to hold the full-precision sum of all channels.
    localparam int SUM_W = WORD_W + SHIFT;

`ifdef I2S_MIX_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SHIFT + 1){1'b0}}, {(WORD_W - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SHIFT + 1){1'b1}}, {(WORD_W - 1){1'b0}}};
`endif

    logic              wsd_q, wsd_d;
    logic              armed_q, armed_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] cap_q [CHANNELS];
    logic [WORD_W-1:0] cap_d [CHANNELS];
    logic [WORD_W-1:0] cap_now [CHANNELS];
    logic [WORD_W-1:0] tx_q, tx_d;
    logic [WORD_W-1:0] word_out_q, word_out_d;
    logic              word_valid_q, word_valid_d;
    logic              word_side_q, word_side_d;
    logic              short_slot_q, short_slot_d;

    logic [WORD_W-1:0]       bit_mask;
    logic [WORD_W-1:0]       xor_w;
    logic signed [SUM_W-1:0] sum_w;
    logic [WORD_W-1:0]       add_w;
    logic [WORD_W-1:0]       avg_w;
    logic [WORD_W-1:0]       mix_w;
    logic                    boundary;

    assign boundary = ws ^ wsd_q;

    // Slot bit number cnt_q lands at position WORD_W-1-cnt_q; once cnt_q
    // reaches WORD_W the mask is zero and further bits are dropped.
    // Including this edge's bit lets a boundary edge see its own last bit.
    always_comb begin
        bit_mask = {1'b1, {(WORD_W - 1){1'b0}}} >> cnt_q;
        for (int c = 0; c < CHANNELS; c++) begin
            cap_now[c] = sd_in[c] ? (cap_q[c] | bit_mask) : cap_q[c];
        end
    end

    always_comb begin
        xor_w = '0;
        sum_w = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            xor_w = xor_w ^ cap_now[c];
            sum_w = sum_w + SUM_W'($signed(cap_now[c]));
        end
`ifdef I2S_MIX_SAT_EN
        if (sum_w > SAT_MAX) begin
            add_w = {1'b0, {(WORD_W - 1){1'b1}}};
        end else if (sum_w < SAT_MIN) begin
            add_w = {1'b1, {(WORD_W - 1){1'b0}}};
        end else begin
            add_w = sum_w[WORD_W-1:0];
        end
`else
        add_w = sum_w[WORD_W-1:0];
`endif
        // Dropping the low bits of a signed value floors toward -inf.
        avg_w = sum_w[SUM_W-1:SHIFT];
        unique case (mode)
            2'b00:   mix_w = cap_now[0];
            2'b01:   mix_w = xor_w;
            2'b10:   mix_w = add_w;
            default: mix_w = avg_w;
        endcase
    end

    always_comb begin
        wsd_d        = ws;
        armed_d      = armed_q;
        cnt_d        = cnt_q;
        cap_d        = cap_now;
        tx_d         = {tx_q[WORD_W-2:0], 1'b0};
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;
        word_side_d  = word_side_q;
        short_slot_d = 1'b0;
        if (boundary) begin
            cnt_d   = '0;
            armed_d = 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
                cap_d[c] = '0;
            end
            // The slot cut by reset release is incomplete: drop it.
            if (armed_q) begin
                word_out_d   = mix_w;
                word_valid_d = 1'b1;
                word_side_d  = wsd_q;
                short_slot_d = (cnt_q < CNT_W'(WORD_W - 1));
                tx_d         = mix_w;
            end
        end else if (cnt_q != CNT_W'(WORD_W)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            wsd_q        <= 1'b0;
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            cap_q        <= '{default: '0};
            tx_q         <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            word_side_q  <= 1'b0;
            short_slot_q <= 1'b0;
        end else begin
            wsd_q        <= wsd_d;
            armed_q      <= armed_d;
            cnt_q        <= cnt_d;
            cap_q        <= cap_d;
            tx_q         <= tx_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            word_side_q  <= word_side_d;
            short_slot_q <= short_slot_d;
        end
    end

    assign wsd        = wsd_q;
    assign wsp        = boundary;
    assign sd_out     = tx_q[WORD_W-1];
    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign word_side  = word_side_q;
    assign short_slot = short_slot_q;

endmodule

// File: tb/tb_i2s_mixer.sv
// tb_i2s_mixer: directed bench for i2s_mixer, a 2-channel and a
// 4-channel instance driven from one ws / bit clock.
module tb_i2s_mixer;

    logic        sck = 1'b0;
    logic        rst_n = 1'b0;
    logic        ws = 1'b0;
    logic [3:0]  sd4 = 4'h0;
    logic [1:0]  mode = 2'b00;

    logic        sd_out, wsd, wsp, word_valid, word_side, short_slot;
    logic [15:0] word_out;
    logic        sd_out4, wsd4, wsp4, word_valid4, word_side4, short_slot4;
    logic [15:0] word_out4;

    int          total = 0;
    int          bad = 0;
    logic        cur_side = 1'b0;
    logic        exp_side;
    logic [15:0] rx;
    logic        tail;
    logic        v1, s1;

    always #5 sck = ~sck;

    i2s_mixer #(.CHANNELS(2), .WORD_W(16)) dut (
        .sck(sck), .rst_n(rst_n), .ws(ws), .sd_in(sd4[1:0]), .mode(mode),
        .sd_out(sd_out), .wsd(wsd), .wsp(wsp), .word_out(word_out),
        .word_valid(word_valid), .word_side(word_side),
        .short_slot(short_slot)
    );

    i2s_mixer #(.CHANNELS(4), .WORD_W(16)) dut4 (
        .sck(sck), .rst_n(rst_n), .ws(ws), .sd_in(sd4), .mode(mode),
        .sd_out(sd_out4), .wsd(wsd4), .wsp(wsp4), .word_out(word_out4),
        .word_valid(word_valid4), .word_side(word_side4),
        .short_slot(short_slot4)
    );

    // One slot of n bits; ws flips on bit n so that edge is the boundary.
    // rx collects sd_out as a receiver would see it on bits 1..16.
    task automatic send_slot(input int n, input logic [15:0] w0,
                             input logic [15:0] w1, input logic [15:0] w2,
                             input logic [15:0] w3, input int chg_at,
                             input logic [1:0] chg_mode);
        logic [15:0] sh [4];
        sh[0] = w0; sh[1] = w1; sh[2] = w2; sh[3] = w3;
        rx = '0;
        tail = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge sck);
            if (i <= 16) rx = {rx[14:0], sd_out};
            else tail = tail | sd_out;
            ws = (i == n) ? ~cur_side : cur_side;
            for (int c = 0; c < 4; c++) begin
                sd4[c] = (i <= 16) ? sh[c][15] : 1'b1;
                sh[c] = {sh[c][14:0], 1'b0};
            end
            if (i == chg_at) mode = chg_mode;
            @(posedge sck);
            #1;
            if (i == 1) begin
                v1 = word_valid;
                s1 = short_slot;
            end
        end
        exp_side = cur_side;
        cur_side = ~cur_side;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge sck);
        #1;
        ws = 1'b1;
        #1;
        total++; if (wsp !== 1'b1) begin bad++; $display("FAIL rst_wsp got %b want 1", wsp); end
        total++; if (wsd !== 1'b0) begin bad++; $display("FAIL rst_wsd got %b want 0", wsd); end
        total++; if (word_out !== 16'h0) begin bad++; $display("FAIL rst_word got %h want 0000", word_out); end
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", word_valid); end
        total++; if (word_side !== 1'b0) begin bad++; $display("FAIL rst_side got %b want 0", word_side); end
        total++; if (short_slot !== 1'b0) begin bad++; $display("FAIL rst_short got %b want 0", short_slot); end
        total++; if (sd_out !== 1'b0) begin bad++; $display("FAIL rst_sd got %b want 0", sd_out); end
        @(negedge sck);
        ws = 1'b0;
        #1;
        total++; if (wsp !== 1'b0) begin bad++; $display("FAIL rst_wsp0 got %b want 0", wsp); end
        @(negedge sck);
        rst_n = 1'b1;
        cur_side = 1'b0;
    endtask

    task automatic test_xor;
        mode = 2'b01;
        send_slot(16, 16'h1111, 16'h2222, 16'h0, 16'h0, 0, 2'b00);
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL xor_first_valid got %b want 0", word_valid); end
        send_slot(16, 16'h1234, 16'h1111, 16'h0, 16'h0, 0, 2'b00);
        total++; if (rx !== 16'h0) begin bad++; $display("FAIL xor_sd_idle got %h want 0000", rx); end
        total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL xor_valid1 got %b want 1", word_valid); end
        total++; if (word_out !== 16'h0325) begin bad++; $display("FAIL xor_word1 got %h want 0325", word_out); end
        total++; if (word_side !== 1'b1) begin bad++; $display("FAIL xor_side1 got %b want 1", word_side); end
        send_slot(16, 16'hA5A5, 16'h0F0F, 16'h0, 16'h0, 0, 2'b00);
        total++; if (word_out !== 16'hAAAA) begin bad++; $display("FAIL xor_word2 got %h want aaaa", word_out); end
        total++; if (word_side !== 1'b0) begin bad++; $display("FAIL xor_side2 got %b want 0", word_side); end
        total++; if (short_slot !== 1'b0) begin bad++; $display("FAIL xor_short2 got %b want 0", short_slot); end
        total++; if (rx !== 16'h0325) begin bad++; $display("FAIL xor_sd1 got %h want 0325", rx); end
        mode = 2'b00;
        send_slot(20, 16'h0000, 16'h0000, 16'h0, 16'h0, 0, 2'b00);
        total++; if (rx !== 16'hAAAA) begin bad++; $display("FAIL xor_sd2 got %h want aaaa", rx); end
        total++; if (tail !== 1'b0) begin bad++; $display("FAIL xor_sd_tail got %b want 0", tail); end
        total++; if (word_out !== 16'h0000) begin bad++; $display("FAIL long_word got %h want 0000", word_out); end
        total++; if (short_slot !== 1'b0) begin bad++; $display("FAIL long_short got %b want 0", short_slot); end
    endtask

    task automatic test_sum;
        mode = 2'b10;
        send_slot(16, 16'h7000, 16'h2000, 16'h0, 16'h0, 0, 2'b00);
`ifdef I2S_MIX_SAT_EN
        total++; if (word_out !== 16'h7FFF) begin bad++; $display("FAIL sum_pos got %h want 7fff", word_out); end
`else
        total++; if (word_out !== 16'h9000) begin bad++; $display("FAIL sum_pos got %h want 9000", word_out); end
`endif
        send_slot(16, 16'h8000, 16'h8000, 16'h0, 16'h0, 0, 2'b00);
`ifdef I2S_MIX_SAT_EN
        total++; if (word_out !== 16'h8000) begin bad++; $display("FAIL sum_neg got %h want 8000", word_out); end
`else
        total++; if (word_out !== 16'h0000) begin bad++; $display("FAIL sum_neg got %h want 0000", word_out); end
`endif
        send_slot(16, 16'h0003, 16'hFFFF, 16'h0, 16'h0, 0, 2'b00);
        total++; if (word_out !== 16'h0002) begin bad++; $display("FAIL sum_mix got %h want 0002", word_out); end
    endtask

    task automatic test_avg;
        mode = 2'b11;
        send_slot(16, 16'hFFFE, 16'h0001, 16'h0, 16'h0, 0, 2'b00);
        total++; if (word_out !== 16'hFFFF) begin bad++; $display("FAIL avg_m1 got %h want ffff", word_out); end
        send_slot(16, 16'h7FFF, 16'h7FFF, 16'h0, 16'h0, 0, 2'b00);
        total++; if (word_out !== 16'h7FFF) begin bad++; $display("FAIL avg_max got %h want 7fff", word_out); end
        send_slot(16, 16'h8000, 16'h8001, 16'h0, 16'h0, 0, 2'b00);
        total++; if (word_out !== 16'h8000) begin bad++; $display("FAIL avg_min got %h want 8000", word_out); end
    endtask

    task automatic test_short;
        mode = 2'b00;
        send_slot(12, 16'hABC0, 16'h1234, 16'h0, 16'h0, 0, 2'b00);
        total++; if (word_out !== 16'hABC0) begin bad++; $display("FAIL short_word got %h want abc0", word_out); end
        total++; if (short_slot !== 1'b1) begin bad++; $display("FAIL short_flag got %b want 1", short_slot); end
        total++; if (word_side !== exp_side) begin bad++; $display("FAIL short_side got %b want %b", word_side, exp_side); end
        send_slot(16, 16'h5A5A, 16'h0, 16'h0, 16'h0, 0, 2'b00);
        total++; if (s1 !== 1'b0) begin bad++; $display("FAIL short_pulse got %b want 0", s1); end
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL valid_pulse got %b want 0", v1); end
        total++; if (word_out !== 16'h5A5A) begin bad++; $display("FAIL full_word got %h want 5a5a", word_out); end
        total++; if (short_slot !== 1'b0) begin bad++; $display("FAIL full_short got %b want 0", short_slot); end
        send_slot(1, 16'h8000, 16'h0, 16'h0, 16'h0, 0, 2'b00);
        total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL one_valid got %b want 1", word_valid); end
        total++; if (word_out !== 16'h8000) begin bad++; $display("FAIL one_word got %h want 8000", word_out); end
        total++; if (short_slot !== 1'b1) begin bad++; $display("FAIL one_short got %b want 1", short_slot); end
        send_slot(16, 16'h0001, 16'h0, 16'h0, 16'h0, 0, 2'b00);
        total++; if (word_out !== 16'h0001) begin bad++; $display("FAIL after_one got %h want 0001", word_out); end
    endtask

    task automatic test_mode_change;
        mode = 2'b00;
        send_slot(16, 16'h1234, 16'h00FF, 16'h0, 16'h0, 8, 2'b01);
        total++; if (word_out !== 16'h12CB) begin bad++; $display("FAIL mchg_xor got %h want 12cb", word_out); end
        send_slot(16, 16'hF0F0, 16'h0F0F, 16'h0, 16'h0, 0, 2'b00);
        total++; if (word_out !== 16'hFFFF) begin bad++; $display("FAIL mchg_hold got %h want ffff", word_out); end
        send_slot(16, 16'h1000, 16'h0100, 16'h0, 16'h0, 5, 2'b10);
        total++; if (word_out !== 16'h1100) begin bad++; $display("FAIL mchg_sum got %h want 1100", word_out); end
    endtask

    task automatic test_four;
        mode = 2'b01;
        send_slot(16, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 2'b00);
        total++; if (word_out4 !== 16'h0000) begin bad++; $display("FAIL four_xor got %h want 0000", word_out4); end
        total++; if (word_valid4 !== 1'b1) begin bad++; $display("FAIL four_valid got %b want 1", word_valid4); end
        total++; if (word_side4 !== exp_side) begin bad++; $display("FAIL four_side got %b want %b", word_side4, exp_side); end
        mode = 2'b10;
        send_slot(16, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 0, 2'b00);
        total++; if (word_out4 !== 16'h000A) begin bad++; $display("FAIL four_sum got %h want 000a", word_out4); end
        mode = 2'b11;
        send_slot(16, 16'h0004, 16'h0004, 16'h0004, 16'h0003, 0, 2'b00);
        total++; if (word_out4 !== 16'h0003) begin bad++; $display("FAIL four_avg got %h want 0003", word_out4); end
        total++; if (word_out !== 16'h0004) begin bad++; $display("FAIL two_avg got %h want 0004", word_out); end
    endtask

    task automatic test_reset_mid;
        mode = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge sck);
            ws = cur_side;
            sd4 = 4'hF;
        end
        @(negedge sck);
        rst_n = 1'b0;
        ws = 1'b0;
        #1;
        total++; if (word_out !== 16'h0) begin bad++; $display("FAIL mid_word got %h want 0000", word_out); end
        total++; if (sd_out !== 1'b0) begin bad++; $display("FAIL mid_sd got %b want 0", sd_out); end
        @(negedge sck);
        rst_n = 1'b1;
        cur_side = 1'b0;
        send_slot(7, 16'hFE00, 16'h0, 16'h0, 16'h0, 0, 2'b00);
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL mid_first got %b want 0", word_valid); end
        total++; if (word_out !== 16'h0) begin bad++; $display("FAIL mid_first_word got %h want 0000", word_out); end
        send_slot(16, 16'h1357, 16'h0, 16'h0, 16'h0, 0, 2'b00);
        total++; if (rx !== 16'h0) begin bad++; $display("FAIL mid_sd_idle got %h want 0000", rx); end
        total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL mid_second got %b want 1", word_valid); end
        total++; if (word_out !== 16'h1357) begin bad++; $display("FAIL mid_second_word got %h want 1357", word_out); end
        total++; if (word_side !== 1'b1) begin bad++; $display("FAIL mid_side got %b want 1", word_side); end
    endtask

    initial begin
        test_reset;
        test_xor;
        test_sum;
        test_avg;
        test_short;
        test_mode_change;
        test_four;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
